// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The bubble control code documents what bubble_id_ex makes execute see.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] CTL_NOP  = 5'd31;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and the sequencer (slave).
// The pipeline drives the decode/execute/memory status; the sequencer returns stall/flush controls.
interface pipeline_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              id_read_reg1;
  logic              id_read_reg2;
  logic [4:0]        id_reg1_addr;
  logic [4:0]        id_reg2_addr;
  logic              ex_mem_read;
  logic [4:0]        ex_write_reg;
  logic              mem_req;
  logic              mem_ready;
  logic              redirect;
  logic              stall_pc;
  logic              stall_if_id;
  logic              stall_ex_mem;
  logic              flush_if_id;
  logic              bubble_id_ex;
  logic [PERF_W-1:0] perf_stall_cycles;
  logic [PERF_W-1:0] perf_flush_cycles;

  modport master (
    output id_read_reg1, id_read_reg2, id_reg1_addr, id_reg2_addr,
           ex_mem_read, ex_write_reg, mem_req, mem_ready, redirect,
    input  stall_pc, stall_if_id, stall_ex_mem, flush_if_id, bubble_id_ex,
           perf_stall_cycles, perf_flush_cycles
  );

  modport slave (
    input  id_read_reg1, id_read_reg2, id_reg1_addr, id_reg2_addr,
           ex_mem_read, ex_write_reg, mem_req, mem_ready, redirect,
    output stall_pc, stall_if_id, stall_ex_mem, flush_if_id, bubble_id_ex,
           perf_stall_cycles, perf_flush_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Combinational load-use detector: a load in execute whose rd feeds a decode source.
// Writes to x0 never create a hazard.
module load_use_detect
  import ctrl_pkg::*;
(
  input  logic       id_read_reg1,
  input  logic       id_read_reg2,
  input  logic [4:0] id_reg1_addr,
  input  logic [4:0] id_reg2_addr,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  output logic       load_use
);

  logic hit1;
  logic hit2;

  assign hit1     = id_read_reg1 && (id_reg1_addr == ex_write_reg);
  assign hit2     = id_read_reg2 && (id_reg2_addr == ex_write_reg);
  assign load_use = ex_mem_read && (ex_write_reg != REG_ZERO) && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use stall, memory-wait freeze, redirect flush.
// Outputs are combinational from state and inputs; HAZARD_PERF_EN adds stall/flush cycle counters.
module pipeline_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int REDIRECT_FLUSH_CYCLES = 2,
  parameter int PERF_W                = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(REDIRECT_FLUSH_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;

  logic load_use;
  logic mem_wait;
  logic start_redirect;
  logic stall_pc, stall_if_id, stall_ex_mem, flush_if_id, bubble_id_ex;

  load_use_detect u_load_use (
    .id_read_reg1 (hz.id_read_reg1),
    .id_read_reg2 (hz.id_read_reg2),
    .id_reg1_addr (hz.id_reg1_addr),
    .id_reg2_addr (hz.id_reg2_addr),
    .ex_mem_read  (hz.ex_mem_read),
    .ex_write_reg (hz.ex_write_reg),
    .load_use     (load_use)
  );

  assign mem_wait = hz.mem_req && !hz.mem_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    start_redirect = 1'b0;
    stall_pc       = 1'b0;
    stall_if_id    = 1'b0;
    stall_ex_mem   = 1'b0;
    flush_if_id    = 1'b0;
    bubble_id_ex   = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = 3'd0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            pend_d  = hz.redirect;
            state_d = MEM_WAIT;
          end else if (hz.redirect) begin
            start_redirect = 1'b1;
          end else if (load_use) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_wait) begin
            if (hz.redirect) pend_d = 1'b1;
          end else if (pend_q || hz.redirect) begin
            start_redirect = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        REDIRECT: begin
          // A memory freeze wins over the flush; the redirect is replayed after it.
          if (mem_wait) begin
            pend_d  = 1'b1;
            state_d = MEM_WAIT;
          end else if (hz.redirect) begin
            start_redirect = 1'b1;
          end else begin
            flush_if_id = 1'b1;
            cnt_d       = cnt_q - 3'd1;
            if (cnt_d == 3'd0) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (mem_wait) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_ex_mem = 1'b1;
      end
      if (start_redirect) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        pend_d       = 1'b0;
        cnt_d        = FLUSH_RELOAD;
        state_d      = (FLUSH_RELOAD != 3'd0) ? REDIRECT : RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    pend_q  <= pend_d;
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_if_id  = stall_if_id;
  assign hz.stall_ex_mem = stall_ex_mem;
  assign hz.flush_if_id  = flush_if_id;
  assign hz.bubble_id_ex = bubble_id_ex;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + PERF_W'(stall_pc);
    perf_flush_d = perf_flush_q + PERF_W'(flush_if_id);
    if (rst) begin
      perf_stall_d = '0;
      perf_flush_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    perf_stall_q <= perf_stall_d;
    perf_flush_q <= perf_flush_d;
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flush_cycles = perf_flush_q;
`else
  localparam logic [PERF_W-1:0] PERF_ZERO = '0;

  assign hz.perf_stall_cycles = PERF_ZERO;
  assign hz.perf_flush_cycles = PERF_ZERO;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations, then random traffic.
// A cycle-level reference model tracks owed flush cycles and memory-wait status.
module tb_pipeline_hazard_ctrl;

  localparam int N  = 2;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.PERF_W(PW)) hz ();

  pipeline_hazard_ctrl #(
    .REDIRECT_FLUSH_CYCLES (N),
    .PERF_W                (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: memory-wait flag, a redirect owed for after the wait, and flush cycles still owed.
  bit          m_wait = 1'b0;
  bit          m_owed = 1'b0;
  int          m_flush_rem = 0;
  logic [PW-1:0] m_pstall = '0;
  logic [PW-1:0] m_pflush = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic eval(output bit mw, output bit e_stall, output bit e_stall_ex,
                      output bit e_flush, output bit e_bubble);
    bit lu, quiet;
    mw = hz.mem_req && !hz.mem_ready;
    lu = hz.ex_mem_read && (hz.ex_write_reg != 5'd0) &&
         ((hz.id_read_reg1 && hz.id_reg1_addr == hz.ex_write_reg) ||
          (hz.id_read_reg2 && hz.id_reg2_addr == hz.ex_write_reg));
    quiet = !m_wait && (m_flush_rem == 0) && !hz.redirect;
    if (rst) begin
      e_stall = 0; e_stall_ex = 0; e_flush = 0; e_bubble = 0;
    end else begin
      e_stall_ex = mw;
      e_stall    = mw || (lu && quiet);
      e_flush    = !mw && (hz.redirect || m_owed || m_flush_rem > 0);
      e_bubble   = !mw && (hz.redirect || m_owed || (lu && quiet));
    end
  endtask

  always @(negedge clk) begin
    bit mw, es, ex, ef, eb;
    logic [PW-1:0] eps, epf;
    if (chk_en) begin
      eval(mw, es, ex, ef, eb);
`ifdef HAZARD_PERF_EN
      eps = m_pstall;
      epf = m_pflush;
`else
      eps = '0;
      epf = '0;
`endif
      chk("m_stall_pc",     32'(hz.stall_pc),     32'(es));
      chk("m_stall_if_id",  32'(hz.stall_if_id),  32'(es));
      chk("m_stall_ex_mem", 32'(hz.stall_ex_mem), 32'(ex));
      chk("m_flush_if_id",  32'(hz.flush_if_id),  32'(ef));
      chk("m_bubble_id_ex", 32'(hz.bubble_id_ex), 32'(eb));
      chk("m_perf_stall",   32'(hz.perf_stall_cycles), 32'(eps));
      chk("m_perf_flush",   32'(hz.perf_flush_cycles), 32'(epf));
    end
  end

  always @(posedge clk) begin
    bit mw, es, ex, ef, eb;
    eval(mw, es, ex, ef, eb);
    if (rst) begin
      m_wait = 0; m_owed = 0; m_flush_rem = 0; m_pstall = '0; m_pflush = '0;
    end else begin
      m_pstall = m_pstall + PW'(es);
      m_pflush = m_pflush + PW'(ef);
      if (mw) begin
        m_owed      = m_owed || hz.redirect || (m_flush_rem > 0);
        m_wait      = 1;
        m_flush_rem = 0;
      end else if (hz.redirect || m_owed) begin
        m_flush_rem = N - 1;
        m_owed      = 0;
        m_wait      = 0;
      end else begin
        if (m_flush_rem > 0) m_flush_rem--;
        m_wait = 0;
      end
    end
  end

  task automatic idle();
    hz.id_read_reg1 = 0; hz.id_read_reg2 = 0;
    hz.id_reg1_addr = 0; hz.id_reg2_addr = 0;
    hz.ex_mem_read  = 0; hz.ex_write_reg = 0;
    hz.mem_req = 0; hz.mem_ready = 0; hz.redirect = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst_stall_pc", 32'(hz.stall_pc), 0);
    chk("rst_stall_ex", 32'(hz.stall_ex_mem), 0);
    chk("rst_flush", 32'(hz.flush_if_id), 0);
    chk("rst_perf_stall", 32'(hz.perf_stall_cycles), 0);
    tick();
    rst = 0;

    // Load-use on rs1, then cleared when execute changes.
    hz.ex_mem_read = 1; hz.ex_write_reg = 5; hz.id_reg1_addr = 5; hz.id_read_reg1 = 1;
    @(negedge clk);
    chk("lu_stall_pc", 32'(hz.stall_pc), 1);
    chk("lu_stall_if_id", 32'(hz.stall_if_id), 1);
    chk("lu_bubble", 32'(hz.bubble_id_ex), 1);
    chk("lu_stall_ex", 32'(hz.stall_ex_mem), 0);
    tick();
    hz.ex_mem_read = 0; hz.ex_write_reg = 7;
    @(negedge clk);
    chk("lu_next_stall", 32'(hz.stall_pc), 0);
    chk("lu_next_bubble", 32'(hz.bubble_id_ex), 0);
    tick();

    // x0 never hazards.
    hz.ex_mem_read = 1; hz.ex_write_reg = 0; hz.id_reg1_addr = 0;
    @(negedge clk);
    chk("x0_stall", 32'(hz.stall_pc), 0);
    chk("x0_bubble", 32'(hz.bubble_id_ex), 0);
    tick();

    // Memory wait of three cycles.
    idle();
    hz.mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_stall_pc", 32'(hz.stall_pc), 1);
      chk("mw_stall_ex", 32'(hz.stall_ex_mem), 1);
      tick();
    end
    hz.mem_ready = 1;
    @(negedge clk);
    chk("mw_ready_stall", 32'(hz.stall_ex_mem), 0);
    chk("mw_ready_flush", 32'(hz.flush_if_id), 0);
    tick();
    idle();
    @(negedge clk);
    chk("mw_after_stall", 32'(hz.stall_pc), 0);
    tick();

    // Redirect pulse.
    hz.redirect = 1;
    @(negedge clk);
    chk("rd_flush0", 32'(hz.flush_if_id), 1);
    chk("rd_bubble0", 32'(hz.bubble_id_ex), 1);
    tick();
    hz.redirect = 0;
    @(negedge clk);
    chk("rd_flush1", 32'(hz.flush_if_id), 1);
    chk("rd_bubble1", 32'(hz.bubble_id_ex), 0);
    tick();
    @(negedge clk);
    chk("rd_flush2", 32'(hz.flush_if_id), 0);
    tick();

    // Redirect in cycle 2 of a four-cycle memory wait.
    hz.mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      hz.redirect = (i == 1);
      @(negedge clk);
      chk("rw_wait_flush", 32'(hz.flush_if_id), 0);
      chk("rw_wait_stall", 32'(hz.stall_ex_mem), 1);
      tick();
    end
    hz.redirect = 0; hz.mem_ready = 1;
    @(negedge clk);
    chk("rw_ready_flush", 32'(hz.flush_if_id), 1);
    chk("rw_ready_bubble", 32'(hz.bubble_id_ex), 1);
    chk("rw_ready_stall", 32'(hz.stall_pc), 0);
    tick();
    idle();
    @(negedge clk);
    chk("rw_tail_flush", 32'(hz.flush_if_id), 1);
    chk("rw_tail_bubble", 32'(hz.bubble_id_ex), 0);
    tick();
    @(negedge clk);
    chk("rw_done_flush", 32'(hz.flush_if_id), 0);
    tick();

    // Reset while waiting with a redirect pending.
    hz.mem_req = 1; hz.redirect = 1;
    @(negedge clk);
    tick();
    hz.redirect = 0;
    @(negedge clk);
    chk("rm_wait_stall", 32'(hz.stall_ex_mem), 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("rm_rst_stall", 32'(hz.stall_pc), 0);
    chk("rm_rst_flush", 32'(hz.flush_if_id), 0);
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    chk("rm_post_flush", 32'(hz.flush_if_id), 0);
    chk("rm_post_perf_stall", 32'(hz.perf_stall_cycles), 0);
    chk("rm_post_perf_flush", 32'(hz.perf_flush_cycles), 0);
    tick();
    @(negedge clk);
    chk("rm_post_flush2", 32'(hz.flush_if_id), 0);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(199) == 0);
      hz.id_read_reg1 = $urandom_range(1);
      hz.id_read_reg2 = $urandom_range(1);
      hz.id_reg1_addr = 5'($urandom_range(3));
      hz.id_reg2_addr = 5'($urandom_range(3));
      hz.ex_mem_read  = ($urandom_range(2) == 0);
      hz.ex_write_reg = 5'($urandom_range(3));
      hz.mem_req      = ($urandom_range(9) < 3);
      hz.mem_ready    = $urandom_range(1);
      hz.redirect     = ($urandom_range(9) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
